rc_tag_manager: RTL and testbench
=================================

Name: rc_tag_manager

Overview:
- Allocates PCIe read-request tags to the DMA reader and tracks every outstanding non-posted read until its completions finish.
- Enforces a completion-buffer budget, counted in dwords, so that completions returning through the RC adapter never overflow downstream buffering.
- Sits beside the RQ/RC AXIS adapters.
  - The request side is in front of the RQ path.
  - The completion side snoops decoded completion header fields at the RC adapter output (start-of-packet beats only).

Parameters:
- NUM_TAGS, 32, number of tags managed; must be a power of 2, 4..256.
- TAG_WIDTH, 5, log2(NUM_TAGS).
- CPL_BUDGET_DW, 1024, completion-buffer capacity in dwords (max 4096).

Ports:
- user_clk  in  1  clock.
- user_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  requester wants a tag.
- req_dwlen  in  10  read length in dwords; 0 encodes 1024.
- req_ready  out  1  tag and budget available.
- req_tag  out  TAG_WIDTH  tag granted; valid when req_valid and req_ready are both high.
- cpl_valid  in  1  one completion header (SOP beat) presented; always accepted.
- cpl_tag  in  8  completion tag.
- cpl_dwlen  in  10  payload dwords; 0 encodes 1024.
- cpl_bytecnt  in  12  remaining byte count; 0 encodes 4096.
- cpl_lowaddr  in  7  lower address.
- cpl_status  in  3  completion status; 0 = SC.
- cpl_poisoned  in  1  EP bit.
- tag_done  out  1  pulse: the request on done_tag has fully completed.
- done_tag  out  TAG_WIDTH  tag released.
- done_err  out  1  the released request ended with error (non-SC status or poisoned data).
- err_unexpected  out  1  pulse: completion for a tag that is not outstanding.
- in_flight  out  TAG_WIDTH+1  number of tags currently allocated.
- budget_used  out  13  dwords currently reserved.

Behaviour:
- Reset: all tags free; in_flight=0; budget_used=0; per-tag error flags cleared. Registered outputs tag_done, done_tag, done_err, err_unexpected are 0 the cycle after reset is sampled.
- Reset mid-operation abandons all outstanding tags; there is no drain.
- State per tag:
  - busy bit (bitmap);
  - reserved length, 11 bits (1..1024);
  - sticky error flag.
- Allocation:
  - req_tag = lowest-index free tag (combinational priority encoder).
  - req_ready = (any tag free) AND (budget_used + dw(req_dwlen) <= CPL_BUDGET_DW).
  - req_ready may depend on req_dwlen. Requesters must hold req_valid and req_dwlen stable until accepted.
  - On accept, in the same clock edge: the busy bit is set, the length is stored, and budget_used increases by dw(req_dwlen).
- Completion handling (one cycle, registered results):
  - Tag is out of range or not busy: err_unexpected=1 for one cycle; no state change.
  - Otherwise the completion is last when cpl_status!=0, OR dw(cpl_dwlen)*4 >= bc(cpl_bytecnt) + cpl_lowaddr[1:0].
  - The sticky error flag is ORed with (cpl_status!=0 | cpl_poisoned).
  - On last:
    - the busy bit clears;
    - budget_used decreases by the stored length;
    - the next cycle drives tag_done=1, done_tag=tag, done_err=the final sticky flag;
    - the flag is then cleared.
  - Non-last completions change only the sticky flag.
- Latency: tag release is visible in req_ready on the cycle after the completion is presented; tag_done rises on that same cycle.
- Simultaneous accept and release:
  - Both take effect, with the budget updated as used + new - freed.
  - The freed tag is not re-grantable in that cycle because the bitmap is read pre-update.
  - Accept and completion for the same tag in one cycle cannot occur: that tag is busy and the completion is processed against the old state.
- Arithmetic widths:
  - lengths are widened to 11 bits;
  - byte counts are widened to 13 bits;
  - the comparison uses 13 bits;
  - budget_used is 13 bits and never wraps, guaranteed by the ready rule.
- Boundaries:
  - All tags busy: req_ready=0.
  - A request with dwlen=0 (1024 dw) is accepted only when budget_used=0 at the default budget.

Decomposition:
- Shared package:
  - CPL_STATUS_SC constant;
  - function dw_len(10b) returning 11b (0 maps to 1024);
  - function byte_cnt(12b) returning 13b (0 maps to 4096).
- One sub-module: rc_tag_prio_enc (lowest-set-bit finder over the free bitmap, parameterised by width).
- Per-tag length and flag storage stays inline as register arrays.

Test Plan:
- Reset, then 3 requests of dwlen 16 -> tags 0,1,2 granted on consecutive cycles; in_flight=3; budget_used=48.
- Tag 1 outstanding with dwlen 32 (128 bytes): completion (dwlen 16, bytecnt 128, lowaddr 0) then (dwlen 16, bytecnt 64, lowaddr 0) -> no tag_done after the first; tag_done with done_tag=1, done_err=0 one cycle after the second; budget_used decreases by 32.
- Completion status=UR (1) on tag 0 -> immediate release, done_err=1; a request for tag 0 in the next cycle gets tag 0 again.
- Completion for tag 7 while not busy -> err_unexpected pulse; in_flight and budget_used unchanged.
- Budget: hold budget_used=1000, then request dwlen 32 -> req_ready=0; complete a 16-dw tag -> req_ready=1 on the next cycle.
- All 32 tags allocated -> req_ready=0. In one cycle, release tag 5 and present a request -> no grant; on the following cycle tag 5 is granted. Assert user_reset with 10 tags busy -> next cycle in_flight=0 and req_tag=0.

Source files
------------

// File: rtl/rc_tag_manager_pkg.sv
// Shared constants and length-decoding helpers for the RC tag manager.
// The PCIe length fields use 0 to encode their maximum value.
package rc_tag_manager_pkg;

    localparam logic [2:0] CPL_STATUS_SC = 3'd0;

    function automatic logic [10:0] dw_len(input logic [9:0] raw);
        return (raw == 10'd0) ? 11'd1024 : {1'b0, raw};
    endfunction

    function automatic logic [12:0] byte_cnt(input logic [11:0] raw);
        return (raw == 12'd0) ? 13'd4096 : {1'b0, raw};
    endfunction

endpackage

// File: rtl/rc_tag_prio_enc.sv
// Lowest-set-bit finder; used to pick the lowest-index free tag.
module rc_tag_prio_enc #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic [WIDTH-1:0] i_bits,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
        o_idx   = '0;
        o_found = 1'b0;
        // Scan downward so the lowest set bit is the last one written and wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_bits[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc_tag_manager.sv
// PCIe read-tag allocator with completion-buffer budget tracking.
// Tags are granted to the DMA reader and released when their final completion header is seen.
module rc_tag_manager
    import rc_tag_manager_pkg::*;
#(
    parameter int NUM_TAGS      = 32,
    parameter int TAG_WIDTH     = 5,
    parameter int CPL_BUDGET_DW = 1024
) (
    input  logic                 user_clk,
    input  logic                 user_reset,
    input  logic                 req_valid,
    input  logic [9:0]           req_dwlen,
    output logic                 req_ready,
    output logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 cpl_valid,
    input  logic [7:0]           cpl_tag,
    input  logic [9:0]           cpl_dwlen,
    input  logic [11:0]          cpl_bytecnt,
    input  logic [6:0]           cpl_lowaddr,
    input  logic [2:0]           cpl_status,
    input  logic                 cpl_poisoned,
    output logic                 tag_done,
    output logic [TAG_WIDTH-1:0] done_tag,
    output logic                 done_err,
    output logic                 err_unexpected,
    output logic [TAG_WIDTH:0]   in_flight,
    output logic [12:0]          budget_used
);

    localparam int         CNT_W      = TAG_WIDTH + 1;
    localparam logic [8:0]  TAG_LIMIT  = 9'(NUM_TAGS);
    localparam logic [12:0] BUDGET_MAX = 13'(CPL_BUDGET_DW);

    logic [NUM_TAGS-1:0]  r_busy;
    logic [NUM_TAGS-1:0]  r_err;
    logic [10:0]          r_len [NUM_TAGS];
    logic [12:0]          r_budget;
    logic [CNT_W-1:0]     r_in_flight;
    logic                 r_tag_done;
    logic [TAG_WIDTH-1:0] r_done_tag;
    logic                 r_done_err;
    logic                 r_err_unexp;

    logic [TAG_WIDTH-1:0] w_grant_idx;
    logic                 w_any_free;
    logic [10:0]          w_req_len;
    logic [12:0]          w_budget_after;
    logic                 w_accept;
    logic [TAG_WIDTH-1:0] w_cpl_idx;
    logic                 w_cpl_in_range;
    logic                 w_cpl_hit;
    logic                 w_cpl_status_err;
    logic                 w_cpl_bad;
    logic [12:0]          w_cpl_bytes;
    logic [12:0]          w_cpl_need;
    logic                 w_cpl_last;
    logic                 w_release;
    logic                 w_flag_next;
    logic [12:0]          w_add_len;
    logic [12:0]          w_sub_len;
    logic                 w_unused;

    rc_tag_prio_enc #(
        .WIDTH (NUM_TAGS),
        .IDX_W (TAG_WIDTH)
    ) u_free_enc (
        .i_bits  (~r_busy),
        .o_idx   (w_grant_idx),
        .o_found (w_any_free)
    );

    // Request side: the grant reads the pre-update bitmap, so a tag freed this cycle waits one cycle.
    assign w_req_len      = dw_len(req_dwlen);
    assign w_budget_after = r_budget + {2'b00, w_req_len};
    assign req_ready      = w_any_free && (w_budget_after <= BUDGET_MAX);
    assign req_tag        = w_grant_idx;
    assign w_accept       = req_valid && req_ready;

    // Completion side: a completion ends the request on error or once it covers the remaining bytes.
    assign w_cpl_idx        = cpl_tag[TAG_WIDTH-1:0];
    assign w_cpl_in_range   = {1'b0, cpl_tag} < TAG_LIMIT;
    assign w_cpl_hit        = cpl_valid && w_cpl_in_range && r_busy[w_cpl_idx];
    assign w_cpl_status_err = (cpl_status != CPL_STATUS_SC);
    assign w_cpl_bad        = w_cpl_status_err || cpl_poisoned;
    assign w_cpl_bytes      = {dw_len(cpl_dwlen), 2'b00};
    assign w_cpl_need       = byte_cnt(cpl_bytecnt) + {11'd0, cpl_lowaddr[1:0]};
    assign w_cpl_last       = w_cpl_status_err || (w_cpl_bytes >= w_cpl_need);
    assign w_release        = w_cpl_hit && w_cpl_last;
    assign w_flag_next      = r_err[w_cpl_idx] || w_cpl_bad;

    assign w_add_len = w_accept  ? {2'b00, w_req_len}        : 13'd0;
    assign w_sub_len = w_release ? {2'b00, r_len[w_cpl_idx]} : 13'd0;

    // Only the dword offset of the lower address affects the byte accounting.
    assign w_unused = &{1'b0, cpl_lowaddr[6:2]};

    // NOTE: sequential state uses non-blocking assignments so every process sees pre-edge values.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_busy      <= '0;
            r_err       <= '0;
            r_budget    <= '0;
            r_in_flight <= '0;
            r_tag_done  <= 1'b0;
            r_done_tag  <= '0;
            r_done_err  <= 1'b0;
            r_err_unexp <= 1'b0;
        end else begin
            if (w_accept)  r_busy[w_grant_idx] <= 1'b1;
            if (w_release) r_busy[w_cpl_idx]   <= 1'b0;
            if (w_cpl_hit) r_err[w_cpl_idx]    <= w_cpl_last ? 1'b0 : w_flag_next;

            r_budget    <= r_budget + w_add_len - w_sub_len;
            r_in_flight <= r_in_flight + CNT_W'(w_accept) - CNT_W'(w_release);

            r_tag_done  <= w_release;
            r_done_err  <= w_release && w_flag_next;
            if (w_release) r_done_tag <= w_cpl_idx;
            r_err_unexp <= cpl_valid && !w_cpl_hit;
        end
    end

    // NOTE: the length array has no reset; an entry is only read while its busy bit is set.
    always_ff @(posedge user_clk) begin
        if (w_accept) r_len[w_grant_idx] <= w_req_len;
    end

    assign tag_done       = r_tag_done;
    assign done_tag       = r_done_tag;
    assign done_err       = r_done_err;
    assign err_unexpected = r_err_unexp;
    assign in_flight      = r_in_flight;
    assign budget_used    = r_budget;

endmodule

// File: tb/tb_rc_tag_manager.sv
// Directed bench for rc_tag_manager; tag releases are checked against a scoreboard of expected done records.
module tb_rc_tag_manager;

    localparam int NT = 32;
    localparam int TW = 5;

    logic          user_clk = 1'b0;
    logic          user_reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [9:0]    req_dwlen = 10'd16;
    logic          req_ready;
    logic [TW-1:0] req_tag;
    logic          cpl_valid = 1'b0;
    logic [7:0]    cpl_tag = '0;
    logic [9:0]    cpl_dwlen = '0;
    logic [11:0]   cpl_bytecnt = '0;
    logic [6:0]    cpl_lowaddr = '0;
    logic [2:0]    cpl_status = '0;
    logic          cpl_poisoned = 1'b0;
    logic          tag_done;
    logic [TW-1:0] done_tag;
    logic          done_err;
    logic          err_unexpected;
    logic [TW:0]   in_flight;
    logic [12:0]   budget_used;

    rc_tag_manager #(
        .NUM_TAGS      (NT),
        .TAG_WIDTH     (TW),
        .CPL_BUDGET_DW (1024)
    ) dut (
        .user_clk       (user_clk),
        .user_reset     (user_reset),
        .req_valid      (req_valid),
        .req_dwlen      (req_dwlen),
        .req_ready      (req_ready),
        .req_tag        (req_tag),
        .cpl_valid      (cpl_valid),
        .cpl_tag        (cpl_tag),
        .cpl_dwlen      (cpl_dwlen),
        .cpl_bytecnt    (cpl_bytecnt),
        .cpl_lowaddr    (cpl_lowaddr),
        .cpl_status     (cpl_status),
        .cpl_poisoned   (cpl_poisoned),
        .tag_done       (tag_done),
        .done_tag       (done_tag),
        .done_err       (done_err),
        .err_unexpected (err_unexpected),
        .in_flight      (in_flight),
        .budget_used    (budget_used)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        int tag;
        bit err;
    } done_t;

    done_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    m_budget = 0;
    int    m_inflight = 0;
    int    m_len [NT];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge user_clk);
        #1;
        cpl_valid = 1'b0;
    endtask

    task automatic model_grant(input int tag, input int dwlen);
        m_len[tag] = (dwlen == 0) ? 1024 : dwlen;
        m_budget   += m_len[tag];
        m_inflight++;
    endtask

    task automatic model_release(input int tag, input bit err);
        done_t d;
        m_budget -= m_len[tag];
        m_inflight--;
        d.tag = tag;
        d.err = err;
        sb.push_back(d);
    endtask

    task automatic set_cpl(input int tag, input int dwlen, input int bc, input int la,
                           input int st, input int ep);
        cpl_valid    = 1'b1;
        cpl_tag      = 8'(tag);
        cpl_dwlen    = 10'(dwlen);
        cpl_bytecnt  = 12'(bc);
        cpl_lowaddr  = 7'(la);
        cpl_status   = 3'(st);
        cpl_poisoned = ep[0];
    endtask

    task automatic req_grant(input int dwlen, input int exp_tag, input string name);
        req_valid = 1'b1;
        req_dwlen = 10'(dwlen);
        #1;
        check({name, "_ready"}, 32'(req_ready), 1);
        check({name, "_tag"}, 32'(req_tag), 32'(exp_tag));
        model_grant(exp_tag, dwlen);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic cpl(input int tag, input int dwlen, input int bc, input int la, input int st,
                       input int ep, input bit last, input bit err, input string name);
        set_cpl(tag, dwlen, bc, la, st, ep);
        if (last) model_release(tag, err);
        tick();
        check({name, "_done"}, 32'(tag_done), 32'(last));
        check({name, "_unexp"}, 32'(err_unexpected), 0);
    endtask

    task automatic cpl_unexp(input int tag, input string name);
        set_cpl(tag, 1, 4, 0, 0, 0);
        tick();
        check({name, "_pulse"}, 32'(err_unexpected), 1);
        check({name, "_nodone"}, 32'(tag_done), 0);
        tick();
        check({name, "_clear"}, 32'(err_unexpected), 0);
    endtask

    task automatic check_totals(input string name);
        check({name, "_inflight"}, 32'(in_flight), 32'(m_inflight));
        check({name, "_budget"}, 32'(budget_used), 32'(m_budget));
    endtask

    // Scoreboard consumer: every tag_done pulse must match the oldest expected release.
    always @(negedge user_clk) begin
        if (tag_done === 1'b1) begin
            check("done_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                done_t d;
                d = sb.pop_front();
                check("done_tag", 32'(done_tag), 32'(d.tag));
                check("done_err", 32'(done_err), 32'(d.err));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        tick();
        tick();
        user_reset = 1'b0;
        #1;
        check("rst_inflight", 32'(in_flight), 0);
        check("rst_budget", 32'(budget_used), 0);
        check("rst_tag_done", 32'(tag_done), 0);
        check("rst_done_tag", 32'(done_tag), 0);
        check("rst_done_err", 32'(done_err), 0);
        check("rst_unexp", 32'(err_unexpected), 0);
        check("rst_ready", 32'(req_ready), 1);
        check("rst_req_tag", 32'(req_tag), 0);

        // Three back-to-back grants
        req_grant(16, 0, "g0");
        req_grant(16, 1, "g1");
        req_grant(16, 2, "g2");
        check("three_inflight", 32'(in_flight), 3);
        check("three_budget", 32'(budget_used), 48);

        // Split completion on a 32-dword read
        cpl(1, 16, 64, 0, 0, 0, 1'b1, 1'b0, "rel1");
        req_grant(32, 1, "g1_32");
        check_totals("g1_32");
        cpl(1, 16, 128, 0, 0, 0, 1'b0, 1'b0, "split_a");
        cpl(1, 16, 64, 0, 0, 0, 1'b1, 1'b0, "split_b");
        check_totals("split");
        check("split_budget", 32'(budget_used), 32);

        // UR status releases immediately with error; the tag is re-grantable next cycle
        cpl(0, 1, 100, 0, 1, 0, 1'b1, 1'b1, "ur");
        req_grant(8, 0, "regrant0");
        check_totals("regrant0");

        // Sticky poison flag and lower-address boundary, ending with simultaneous accept and release
        cpl(2, 8, 64, 0, 0, 1, 1'b0, 1'b0, "poison");
        cpl(2, 8, 30, 3, 0, 0, 1'b0, 1'b0, "la3_short");
        req_valid = 1'b1;
        req_dwlen = 10'd4;
        set_cpl(2, 8, 30, 2, 0, 0);
        #1;
        check("simul_ready", 32'(req_ready), 1);
        check("simul_tag", 32'(req_tag), 1);
        model_grant(1, 4);
        model_release(2, 1'b1);
        tick();
        req_valid = 1'b0;
        check("simul_done", 32'(tag_done), 1);
        check_totals("simul");

        // Completions for tags that are not outstanding
        cpl_unexp(7, "unexp7");
        cpl_unexp(200, "unexp200");
        check_totals("unexp");

        // Budget limit
        req_dwlen = 10'd0;
        #1;
        check("dw1024_blocked", 32'(req_ready), 0);
        req_grant(972, 2, "big");
        req_grant(16, 3, "fill");
        check("budget_1000", 32'(budget_used), 1000);
        req_dwlen = 10'd24;
        #1;
        check("budget_exact_fit", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_dwlen = 10'd32;
        #1;
        check("budget_over", 32'(req_ready), 0);
        tick();
        check("budget_held", 32'(req_ready), 0);
        set_cpl(3, 16, 64, 0, 0, 0);
        model_release(3, 1'b0);
        #1;
        check("budget_same_cycle", 32'(req_ready), 0);
        tick();
        check("budget_rel_done", 32'(tag_done), 1);
        check("budget_freed_ready", 32'(req_ready), 1);
        check("budget_freed_tag", 32'(req_tag), 3);
        model_grant(3, 32);
        tick();
        req_valid = 1'b0;
        check_totals("budget_regrant");

        // Drain, then a full 1024-dword read at zero budget
        cpl(0, 8, 32, 0, 0, 0, 1'b1, 1'b0, "drain0");
        cpl(1, 4, 16, 0, 0, 0, 1'b1, 1'b0, "drain1");
        cpl(2, 972, 3888, 0, 0, 0, 1'b1, 1'b0, "drain2");
        cpl(3, 32, 128, 0, 0, 0, 1'b1, 1'b0, "drain3");
        check_totals("drained");
        req_grant(0, 0, "g1024");
        check("budget_1024", 32'(budget_used), 1024);
        cpl(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, "rel1024");
        check_totals("rel1024");

        // All tags busy; a release is not re-granted in the same cycle
        for (int i = 0; i < NT; i++) req_grant(1, i, "fill_all");
        check_totals("all_busy");
        req_valid = 1'b1;
        req_dwlen = 10'd1;
        #1;
        check("all_busy_ready", 32'(req_ready), 0);
        set_cpl(5, 1, 4, 0, 0, 0);
        model_release(5, 1'b0);
        #1;
        check("rel5_same_cycle", 32'(req_ready), 0);
        tick();
        check("rel5_done", 32'(tag_done), 1);
        check("rel5_ready", 32'(req_ready), 1);
        check("rel5_tag", 32'(req_tag), 5);
        model_grant(5, 1);
        tick();
        req_valid = 1'b0;
        check_totals("rel5_regrant");

        // Reset abandons outstanding tags
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        m_budget   = 0;
        m_inflight = 0;
        check_totals("rst_full");
        check("rst_full_tag", 32'(req_tag), 0);
        for (int i = 0; i < 10; i++) req_grant(2, i, "ten");
        check_totals("ten_busy");
        user_reset = 1'b1;
        tick();
        user_reset = 1'b0;
        m_budget   = 0;
        m_inflight = 0;
        check_totals("rst_ten");
        check("rst_ten_tag", 32'(req_tag), 0);
        check("rst_ten_done", 32'(tag_done), 0);
        cpl_unexp(3, "abandoned3");

        tick();
        check("sb_empty", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
